// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-block read-only instruction cache with a two-state miss-fill FSM.
// Optional hit/fill statistics counters are compiled in when ICACHE_STATS_EN is defined.
module icache_responder #(
  parameter  int NFRAMES = 16,
  localparam int IDX_W   = $clog2(NFRAMES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic        o_dbg_state
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t             r_state;
  logic [NFRAMES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag_arr [NFRAMES];
  logic [31:0]        r_data    [NFRAMES];

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic             w_match;
  logic             w_hit_idle;
  logic             w_fill_done;
  logic             w_unused_lsb;

  assign w_tag        = imemaddr[31:IDX_W+2];
  assign w_idx        = imemaddr[IDX_W+1:2];
  assign w_unused_lsb = ^imemaddr[1:0];

  assign w_match     = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
  assign w_hit_idle  = (r_state == IDLE) && imemREN && w_match;
  assign w_fill_done = (r_state == FILL) && !iwait;

  // iload only reaches the outputs on the fill completion cycle.
  assign ihit        = w_hit_idle || (w_fill_done && imemREN);
  assign imemload    = w_fill_done ? iload : (w_hit_idle ? r_data[w_idx] : 32'h0);
  assign iREN        = (r_state == FILL);
  assign iaddr       = iREN ? {imemaddr[31:2], 2'b00} : 32'h0;
  assign o_dbg_state = (r_state == FILL);

  // FILL doubles as the registered miss-pending flag; the fill is written
  // under whatever tag/index is live on the completion cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (imemREN && !w_match) r_state <= FILL;
        end
        FILL: begin
          if (!iwait) begin
            r_state        <= IDLE;
            r_valid[w_idx] <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag_arr[w_idx] <= w_tag;
      r_data[w_idx]    <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (w_hit_idle)  hit_count  <= hit_count + 32'h1;
      if (w_fill_done) miss_count <= miss_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus random traffic against a word-level cache model.
// Expected per-cycle outputs are queued by the driver and compared by a negedge monitor.
module tb_icache_responder;
  localparam int NF = 16;
  localparam int W  = 66;

  logic        CLK, nRST;
  logic        imemREN, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN, o_dbg_state;
  logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_responder #(.NFRAMES(NF)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: each frame remembers which word address it holds.
  bit          m_valid [NF];
  logic [29:0] m_word  [NF];
  logic [31:0] m_data  [NF];
  bit          m_pend;
  int unsigned m_hits, m_fills;
  logic [31:0] mem [logic [29:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return ({2'b00, a[31:2]} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_valid[i] = 1'b0;
    m_pend  = 1'b0;
    m_hits  = 0;
    m_fills = 0;
  endtask

  // Drive one cycle starting just after a rising edge; returns whether ihit is expected.
  task automatic cycle(input bit ren, input logic [31:0] addr, input bit wt, output bit got);
    int          idx;
    bit          hit, done;
    logic [31:0] load;
    idx  = int'((addr >> 2) % NF);
    load = wt ? $urandom : mem_word(addr);
    imemREN = ren; imemaddr = addr; iwait = wt; iload = load;
    hit  = 1'b0;
    done = 1'b0;
    if (!m_pend) begin
      hit = ren && m_valid[idx] && (m_word[idx] == addr[31:2]);
      exp_q.push_back({hit, hit ? m_data[idx] : 32'h0, 1'b0, 32'h0});
      got = hit;
    end else begin
      done = !wt;
      exp_q.push_back({done && ren, done ? load : 32'h0, 1'b1, {addr[31:2], 2'b00}});
      got = done && ren;
    end
    @(posedge CLK);
    if (!m_pend) begin
      if (hit) m_hits++;
      else if (ren) m_pend = 1'b1;
    end else if (done) begin
      m_valid[idx] = 1'b1;
      m_word[idx]  = addr[31:2];
      m_data[idx]  = load;
      m_pend       = 1'b0;
      m_fills++;
    end
    #1;
  endtask

  // Hold a request until it is served; nwait = memory busy cycles once the fill starts.
  task automatic fetch(input logic [31:0] addr, input int nwait);
    bit got;
    bit wt;
    int w;
    int n;
    got = 1'b0;
    w   = nwait;
    n   = 0;
    while (!got && n < 20) begin
      wt = m_pend ? (w > 0) : 1'b1;
      if (m_pend && w > 0) w--;
      cycle(1'b1, addr, wt, got);
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fetch_timeout: addr=%h not served within %0d cycles", addr, n);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check("rst_iREN", {31'h0, iREN}, 32'h0);
    check("rst_ihit", {31'h0, ihit}, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_state", {31'h0, o_dbg_state}, 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ihit", {31'h0, ihit}, {31'h0, e[65]});
      check("imemload", imemload, e[64:33]);
      check("iREN", {31'h0, iREN}, {31'h0, e[32]});
      check("iaddr", iaddr, e[31:0]);
    end
  end

  initial begin
    bit          got;
    logic [31:0] a;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    mem[30'h0]  = 32'h8C010004;
    mem[30'h1]  = 32'h20020001;
    mem[30'h11] = 32'hAC020008;
    mem[30'hC]  = 32'h3C01FFFF;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // miss with two busy cycles, then a zero-latency hit
    fetch(32'h0, 2);
    cycle(1'b1, 32'h0, 1'b1, got);
    check("hit_after_fill", {31'h0, got}, 32'h1);

    // conflict miss on index 1
    fetch(32'h4, 1);
    fetch(32'h44, 0);
    cycle(1'b1, 32'h44, 1'b1, got);
    check("conflict_resident", {31'h0, got}, 32'h1);
    fetch(32'h4, 1);

    // byte offset ignored
    fetch(32'h10, 0);
    cycle(1'b1, 32'h13, 1'b1, got);
    check("offset_hit", {31'h0, got}, 32'h1);

    // reset mid-fill with the request still raised
    cycle(1'b1, 32'h20, 1'b1, got);
    cycle(1'b1, 32'h20, 1'b1, got);
    do_reset();
    cycle(1'b1, 32'h20, 1'b1, got);
    check("post_reset_miss", {31'h0, got}, 32'h0);
    fetch(32'h20, 0);

    // request dropped during fill
    cycle(1'b1, 32'h30, 1'b1, got);
    cycle(1'b0, 32'h30, 1'b1, got);
    cycle(1'b0, 32'h30, 1'b0, got);
    cycle(1'b0, 32'h30, 1'b1, got);
    cycle(1'b1, 32'h30, 1'b1, got);
    check("drop_then_hit", {31'h0, got}, 32'h1);

`ifdef ICACHE_STATS_EN
    do_reset();
    fetch(32'h200, 1);
    fetch(32'h204, 0);
    fetch(32'h208, 2);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h200 + 32'(4 * (i % 3)), 1'b1, got);
    check("miss_count_3", miss_count, 32'd3);
    check("hit_count_5", hit_count, 32'd5);
`endif

    // random traffic, including protocol-illegal redirects during a fill
    a = 32'h0;
    for (int i = 0; i < 800; i++) begin
      if (!m_pend || $urandom_range(0, 9) == 0)
        a = 32'($urandom_range(0, 1) * 32'h400) + 32'($urandom_range(0, NF - 1) << 2)
          + 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 4) != 0, a, $urandom_range(0, 2) != 0, got);
    end

`ifdef ICACHE_STATS_EN
    check("hit_count_model", hit_count, m_hits);
    check("miss_count_model", miss_count, m_fills);
`endif

    imemREN = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, one-word-per-block instruction cache that answers the pipeline's instruction-fetch requests.
- Datapath side: imemREN, imemaddr, ihit, imemload of datapath_cache_if.
- Memory side: iREN, iaddr, iwait, iload toward the memory controller.
- Hits return in the request cycle. Misses fill from memory through a two-state FSM and forward the fetched word on completion.

Parameters:
- NFRAMES, 16, number of cache frames; must be a power of 2 and at least 2.
- IDX_W, $clog2(NFRAMES), index width, derived; not to be overridden.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  datapath fetch byte address (word_t)
- ihit  out  1  fetch satisfied this cycle
- imemload  out  32  instruction word returned
- iREN  out  1  read request to memory controller
- iaddr  out  32  word-aligned memory read address
- iwait  in  1  memory busy; iload is valid when iREN=1 and iwait=0
- iload  in  32  memory read data
- hit_count  out  32  (ICACHE_STATS_EN only) completed hits
- miss_count  out  32  (ICACHE_STATS_EN only) completed fills

Behaviour:
- Address split: tag = imemaddr[31:IDX_W+2], index = imemaddr[IDX_W+1:2]. Bits [1:0] are ignored.
- Storage per frame: valid bit, tag, data word. No dirty bit; the cache is read-only.
- Reset (asynchronous, nRST=0), effective immediately:
  - all valid bits clear; state = IDLE
  - iREN=0, ihit=0, imemload=0, iaddr=0, counters=0
  - tag and data contents need not be reset
- States: IDLE, FILL.
- IDLE:
  - match = valid[index] && tag_arr[index]==tag.
  - imemREN && match: ihit=1 and imemload=data[index], combinationally in the same cycle. Stay in IDLE.
  - imemREN && !match: ihit=0; next state FILL. The miss is latched into a registered pending flag.
  - imemREN=0: ihit=0, imemload=0, iREN=0.
- FILL:
  - Drive iREN=1 and iaddr = {imemaddr[31:2],2'b00}. iaddr is combinational from the live imemaddr.
  - While iwait=1: ihit=0; stay in FILL.
  - iwait=0:
    - On the clock edge: write data[index]=iload, tag_arr[index]=tag, valid[index]=1.
    - In the same cycle: ihit=imemREN and imemload=iload (forwarded).
    - Next state IDLE.
  - One-cycle bubble after a fill. When imemREN is still high, the next IDLE cycle hits the just-written frame for the same address.
- Miss latency: 1 cycle to enter FILL, plus the memory wait cycles, plus the completion cycle. Hit latency is 0 cycles.
- imemREN drops during FILL:
  - The fill still completes and the frame is written.
  - ihit stays 0 while imemREN=0.
- imemaddr changes during FILL (pipeline redirect):
  - iaddr follows the new address.
  - The word returned with iwait=0 is written under the tag/index current in that cycle.
  - The datapath holds imemaddr stable until ihit, so this case is protocol-illegal but must not corrupt a frame with a mismatched tag.
- Conflict miss to a valid frame: the old line is overwritten on fill completion. No write-back.
- Outputs must not depend combinationally on iload except in FILL with iwait=0.
- Reset during FILL: the FSM returns to IDLE and iREN drops at once. The partially served address is not marked valid.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each IDLE cycle with imemREN && match.
  - miss_count increments on each FILL completion cycle (iwait=0).
  - Both wrap modulo 2^32, reset to 0, and are exposed as outputs.
- Undefined: the hit_count and miss_count ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000000, memory iwait=1 for 2 cycles then iload=0x8C010004 -> iREN=1 with iaddr=0x00000000 for 3 cycles; ihit=1 and imemload=0x8C010004 in the 3rd cycle; the next cycle hits with ihit=1 and the same data; iREN=0.
- Fill 0x00000004 (iload=0x20020001). Then request 0x00000044, which has the same index (1) and a different tag (iload=0xAC020008). Re-request 0x00000004 -> a fresh miss with iREN=1; the frame held 0xAC020008 before the refill.
- imemaddr=0x00000013 after filling 0x00000010 -> hit; bits [1:0] are ignored.
- Assert nRST=0 mid-FILL while iwait=1, release, request the same address -> iREN=0 immediately on reset; the post-reset request misses again (valid bit never set).
- Drop imemREN during FILL, then iwait=0 with iload=0x3C01FFFF -> ihit=0 that cycle; a later request to the same address hits in 0 cycles with 0x3C01FFFF.
- ICACHE_STATS_EN defined: 3 distinct misses, then 5 hits -> miss_count=3, hit_count=5. Built without the macro -> the bench compiles with the counter ports absent and all other results unchanged.
